// File: rtl/seq_mem_responder_if.sv
// Bundles the core-side memory bus and the host loader stream of seq_mem_responder.
// Latency: none, signal bundle only.
// Backpressure: the loader stream uses ld_valid/ld_ready; the core bus has no stall.
interface seq_mem_responder_if #(
    parameter int D_SIZE = 32,
    parameter int A_SIZE = 10
);
    // core program port
    logic [A_SIZE-1:0] pc;
    logic [15:0]       instruction;
    // core data port
    logic              read;
    logic              write;
    logic [A_SIZE-1:0] address;
    logic [D_SIZE-1:0] data_out;
    logic [D_SIZE-1:0] data_in;
    // host loader stream
    logic              ld_valid;
    logic              ld_ready;
    logic              ld_sel;
    logic [D_SIZE-1:0] ld_data;
    logic              ld_last;

    // requester side: the core plus the boot host
    modport master (
        output pc, read, write, address, data_out,
        output ld_valid, ld_sel, ld_data, ld_last,
        input  instruction, data_in, ld_ready
    );

    // responder side: seq_mem_responder
    modport slave (
        input  pc, read, write, address, data_out,
        input  ld_valid, ld_sel, ld_data, ld_last,
        output instruction, data_in, ld_ready
    );
endinterface

// File: rtl/seq_mem_responder.sv
// Program/data memory for seq_core with a boot loader that holds the core in reset while loading.
// Latency: instruction is combinational from pc; data_in is registered one cycle after read.
// Backpressure: ld_ready is high only in LOAD; the core data port never stalls.
module seq_mem_responder #(
    parameter int D_SIZE  = 32,
    parameter int A_SIZE  = 10,
    parameter int D_DEPTH = 1024
) (
    input  logic clk,
    input  logic rst_n,
    output logic core_rst_n,
    output logic boot_done,
    output logic err_rw,
    seq_mem_responder_if.slave bus
);

    localparam int              DW     = (D_DEPTH > 1) ? $clog2(D_DEPTH) : 1;
    localparam logic [A_SIZE:0] D_LIM  = (A_SIZE + 1)'(D_DEPTH);
    localparam logic [DW-1:0]   D_LAST = DW'(D_DEPTH - 1);

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [A_SIZE-1:0] p_ptr;
    logic [DW-1:0]     d_ptr;

    logic [15:0]       prog_mem [2**A_SIZE];
    logic [D_SIZE-1:0] data_mem [D_DEPTH];

    logic              ld_fire;
    logic              in_range;
    logic [DW-1:0]     d_idx;
    logic              run_wr;
    logic              run_rd;
    logic              run_clash;

    assign ld_fire   = bus.ld_valid & bus.ld_ready;
    // Compare one bit wider so D_DEPTH == 2**A_SIZE is representable.
    assign in_range  = ({1'b0, bus.address} < D_LIM);
    assign d_idx     = bus.address[DW-1:0];
    // A simultaneous read+write still performs the write; only the read is suppressed.
    assign run_wr    = (state == RUN) & bus.write & in_range;
    assign run_rd    = (state == RUN) & bus.read & ~bus.write;
    assign run_clash = (state == RUN) & bus.read & bus.write;

    // Fetch path is zero latency: the core registers instruction itself.
    assign bus.instruction = prog_mem[bus.pc];

    // Next-state and loader handshake decode.
    always_comb begin
        state_nxt    = state;
        bus.ld_ready = 1'b0;
        case (state)
            LOAD: begin
                bus.ld_ready = 1'b1;
                if (bus.ld_valid && bus.ld_last) begin
                    state_nxt = RELEASE;
                end
            end
            RELEASE: state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = LOAD;
        endcase
    end

    // Control state, load pointers, core reset release, read data and error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= LOAD;
            p_ptr       <= '0;
            d_ptr       <= '0;
            core_rst_n  <= 1'b0;
            boot_done   <= 1'b0;
            err_rw      <= 1'b0;
            bus.data_in <= '0;
        end else begin
            state <= state_nxt;
            // Registered from next state so the first high cycle is the first RUN cycle.
            core_rst_n <= (state_nxt == RUN);
            boot_done  <= (state_nxt == RUN);
            if (ld_fire) begin
                if (bus.ld_sel) begin
                    d_ptr <= (d_ptr == D_LAST) ? '0 : d_ptr + 1'b1;
                end else begin
                    p_ptr <= p_ptr + 1'b1;
                end
            end
            if (run_rd) begin
                bus.data_in <= in_range ? data_mem[d_idx] : '0;
            end
            if (run_clash) begin
                err_rw <= 1'b1;
            end
        end
    end

    // Memory arrays are not reset; loader and core writes never overlap in time.
    always_ff @(posedge clk) begin
        if (ld_fire) begin
            if (bus.ld_sel) begin
                data_mem[d_ptr] <= bus.ld_data;
            end else begin
                prog_mem[p_ptr] <= bus.ld_data[15:0];
            end
        end else if (run_wr) begin
            data_mem[d_idx] <= bus.data_out;
        end
    end

endmodule
